// File: rtl/spi_pkg.sv
// Shared SPI definitions: default word length and slave FSM state encodings.
package spi_pkg;

    localparam int SPI_TRF_BIT_DEFAULT = 12;

    typedef logic [1:0] spi_state_t;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] SHIFT = 2'b01;
    localparam logic [1:0] DONE  = 2'b10;

endpackage

// File: rtl/spi_edge_detect.sv
// Optional two-flop synchroniser followed by a rise/fall detector on one line.
// With SPI_SLAVE_SYNC_EN defined the input passes through two flops before
// edge detection; otherwise it is used directly (master must share clk).
module spi_edge_detect #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic s,
    output logic rise,
    output logic fall
);

    logic prev_q;
    logic prev_d;

`ifdef SPI_SLAVE_SYNC_EN
    logic [1:0] sync_q;
    logic [1:0] sync_d;

    // Shift the raw input through the two synchroniser stages.
    always_comb begin
        sync_d = {sync_q[0], d};
    end

    // Synchroniser flops reset to the line's idle level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= {2{RST_VAL}};
        else     sync_q <= sync_d;
    end

    assign s = sync_q[1];
`else
    assign s = d;
`endif

    // Previous-value register feeding the edge compare.
    always_comb begin
        prev_d = s;
    end

    // Holds last cycle's level of the (synchronised) line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev_q <= RST_VAL;
        else     prev_q <= prev_d;
    end

    assign rise = ~prev_q &  s;
    assign fall =  prev_q & ~s;

endmodule

// File: rtl/spi_slave.sv
// SPI slave endpoint: samples mosi on sclk falling edges, drives miso on
// sclk rising edges, MSB first, one word per chip-select frame.
// Optional macro SPI_SLAVE_SYNC_EN inserts 2-flop synchronisers on sclk, cs
// and mosi for masters that do not share clk.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no frame; miso low, counters cleared, waiting for cs fall
// SHIFT | frame in progress; shifting tx on rise, rx on fall
// DONE  | word delivered; ignore trailing sclk edges until cs rises
module spi_slave
    import spi_pkg::*;
#(
    parameter int SPI_TRF_BIT = SPI_TRF_BIT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sclk,
    input  logic                   cs,
    input  logic                   mosi,
    output logic                   miso,
    input  logic [SPI_TRF_BIT-1:0] tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic [SPI_TRF_BIT-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   frame_err,
    output logic                   tx_underrun,
    output logic                   busy
);

    localparam logic [3:0] TRF_N    = 4'(SPI_TRF_BIT);
    localparam logic [3:0] TRF_LAST = 4'(SPI_TRF_BIT - 1);

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s;
    logic settled;

    spi_edge_detect #(.RST_VAL(1'b0)) u_sclk_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (sclk),
        .s    (sclk_s),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_edge_detect #(.RST_VAL(1'b1)) u_cs_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (cs),
        .s    (cs_s),
        .rise (cs_rise),
        .fall (cs_fall)
    );

`ifdef SPI_SLAVE_SYNC_EN
    logic [1:0] mosi_sync_q;
    logic [1:0] mosi_sync_d;
    logic [1:0] settle_q;
    logic [1:0] settle_d;

    // mosi gets the same two-stage delay as sclk so data stays aligned to its edge;
    // settle tracks when the cs synchroniser has flushed its reset value.
    always_comb begin
        mosi_sync_d = {mosi_sync_q[0], mosi};
        settle_d    = {settle_q[0], 1'b1};
    end

    // mosi synchroniser and post-reset settle tracker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mosi_sync_q <= 2'b00;
            settle_q    <= 2'b00;
        end else begin
            mosi_sync_q <= mosi_sync_d;
            settle_q    <= settle_d;
        end
    end

    assign mosi_s  = mosi_sync_q[1];
    assign settled = settle_q[1];
`else
    assign mosi_s  = mosi;
    assign settled = 1'b1;
`endif

    spi_state_t             state_q,       state_d;
    logic [3:0]             bit_cnt_q,     bit_cnt_d;
    logic [3:0]             tx_cnt_q,      tx_cnt_d;
    logic [SPI_TRF_BIT-1:0] rx_sr_q,       rx_sr_d;
    logic [SPI_TRF_BIT-1:0] tx_sr_q,       tx_sr_d;
    logic [SPI_TRF_BIT-1:0] tx_buf_q,      tx_buf_d;
    logic                   tx_full_q,     tx_full_d;
    logic [SPI_TRF_BIT-1:0] rx_data_q,     rx_data_d;
    logic                   rx_valid_q,    rx_valid_d;
    logic                   frame_err_q,   frame_err_d;
    logic                   tx_underrun_q, tx_underrun_d;
    logic                   miso_q,        miso_d;
    logic                   cs_armed_q,    cs_armed_d;
    logic                   frame_start;

    // A cs low that is already present when reset releases must not start a
    // frame, so cs falls only count once cs has been seen high after reset.
    assign frame_start = (state_q == IDLE) && cs_fall && cs_armed_q;

    // Next-state logic: TX buffer handshake plus the frame FSM.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        tx_cnt_d      = tx_cnt_q;
        rx_sr_d       = rx_sr_q;
        tx_sr_d       = tx_sr_q;
        tx_buf_d      = tx_buf_q;
        tx_full_d     = tx_full_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        frame_err_d   = 1'b0;
        tx_underrun_d = 1'b0;
        miso_d        = miso_q;
        cs_armed_d    = cs_armed_q | (cs_s & settled);

        // Frame start empties the buffer first, so a same-cycle load lands
        // in the buffer for the following frame.
        if (frame_start) begin
            tx_full_d = 1'b0;
        end
        if (tx_valid && !tx_full_q) begin
            tx_buf_d  = tx_data;
            tx_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                bit_cnt_d = 4'd0;
                tx_cnt_d  = 4'd0;
                miso_d    = 1'b0;
                if (frame_start) begin
                    tx_sr_d       = tx_full_q ? tx_buf_q : '0;
                    tx_underrun_d = ~tx_full_q;
                    rx_sr_d       = '0;
                    state_d       = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    frame_err_d = 1'b1;
                    rx_sr_d     = '0;
                    tx_sr_d     = '0;
                    miso_d      = 1'b0;
                    state_d     = IDLE;
                end else begin
                    if (sclk_rise && (tx_cnt_q < TRF_N)) begin
                        miso_d   = tx_sr_q[SPI_TRF_BIT-1];
                        tx_sr_d  = {tx_sr_q[SPI_TRF_BIT-2:0], 1'b0};
                        tx_cnt_d = tx_cnt_q + 4'd1;
                    end
                    if (sclk_fall && (bit_cnt_q < TRF_N)) begin
                        rx_sr_d   = {rx_sr_q[SPI_TRF_BIT-2:0], mosi_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        // Deliver the word on the edge carrying the last bit
                        // so rx_valid lands one clk after that edge.
                        if (bit_cnt_q == TRF_LAST) begin
                            rx_data_d  = {rx_sr_q[SPI_TRF_BIT-2:0], mosi_s};
                            rx_valid_d = 1'b1;
                            state_d    = DONE;
                        end
                    end
                end
            end
            DONE: begin
                miso_d = 1'b0;
                if (cs_s && !sclk_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                miso_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            bit_cnt_q     <= 4'd0;
            tx_cnt_q      <= 4'd0;
            rx_sr_q       <= '0;
            tx_sr_q       <= '0;
            tx_buf_q      <= '0;
            tx_full_q     <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            tx_underrun_q <= 1'b0;
            miso_q        <= 1'b0;
            cs_armed_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            tx_cnt_q      <= tx_cnt_d;
            rx_sr_q       <= rx_sr_d;
            tx_sr_q       <= tx_sr_d;
            tx_buf_q      <= tx_buf_d;
            tx_full_q     <= tx_full_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_err_q   <= frame_err_d;
            tx_underrun_q <= tx_underrun_d;
            miso_q        <= miso_d;
            cs_armed_q    <= cs_armed_d;
        end
    end

    assign miso        = miso_q;
    assign tx_ready    = ~tx_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_err   = frame_err_q;
    assign tx_underrun = tx_underrun_q;
    assign busy        = (state_q == SHIFT) || (state_q == DONE);

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: table of full-duplex frames plus hand-written
// abort, back-to-back, reset-mid-frame and trailing-edge sequences.
module tb_spi_slave;

    localparam int N = 12;

    logic         clk = 1'b0;
    logic         rst;
    logic         sclk, cs, mosi;
    logic         miso;
    logic [N-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [N-1:0] rx_data;
    logic         rx_valid, frame_err, tx_underrun, busy;

    int n_cmp = 0;
    int n_err = 0;
    int rxv_cnt = 0;
    int ferr_cnt = 0;
    int ur_cnt = 0;

    spi_slave #(.SPI_TRF_BIT(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .sclk        (sclk),
        .cs          (cs),
        .mosi        (mosi),
        .miso        (miso),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_err   (frame_err),
        .tx_underrun (tx_underrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid)    rxv_cnt++;
        if (frame_err)   ferr_cnt++;
        if (tx_underrun) ur_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input logic [N-1:0] w);
        tx_data  = w;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tick(1);
    endtask

    task automatic shift_bits(input logic [N-1:0] w, input int n, output logic [N-1:0] got);
        got = '0;
        for (int i = 0; i < n; i++) begin
            mosi = w[N-1-i];
            sclk = 1'b1;
            tick(4);
            got  = {got[N-2:0], miso};
            sclk = 1'b0;
            tick(4);
        end
    endtask

    typedef struct {
        logic         load;
        logic [N-1:0] tx;
        logic [N-1:0] mosi_w;
        logic [N-1:0] exp_miso;
        logic         exp_ur;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [N-1:0] got;
        int rxv0, fe0, ur0;

        vecs[0] = '{1'b1, 12'hA5C, 12'h3F1, 12'hA5C, 1'b0};
        vecs[1] = '{1'b0, 12'h000, 12'h001, 12'h000, 1'b1};
        vecs[2] = '{1'b1, 12'h5A3, 12'hC3C, 12'h5A3, 1'b0};
        vecs[3] = '{1'b1, 12'hFFF, 12'h800, 12'hFFF, 1'b0};

        rst = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
        tx_data = '0; tx_valid = 1'b0;
        tick(3);
        check("rst_miso",     32'(miso),     32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_rx_data",  32'(rx_data),  32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_pulses",   32'(rx_valid | frame_err | tx_underrun), 32'd0);
        rst = 1'b0;
        tick(3);

        // Table of complete frames.
        for (int v = 0; v < 4; v++) begin
            if (vecs[v].load) begin
                load_tx(vecs[v].tx);
                check("tx_ready_full", 32'(tx_ready), 32'd0);
            end
            rxv0 = rxv_cnt; fe0 = ferr_cnt; ur0 = ur_cnt;
            cs = 1'b0;
            tick(4);
            check("busy_in_frame",  32'(busy),     32'd1);
            check("tx_ready_start", 32'(tx_ready), 32'd1);
            shift_bits(vecs[v].mosi_w, N, got);
            tick(2);
            check("miso_word",  32'(got),             32'(vecs[v].exp_miso));
            check("rx_data",    32'(rx_data),         32'(vecs[v].mosi_w));
            check("rx_valid_n", 32'(rxv_cnt - rxv0),  32'd1);
            check("underrun_n", 32'(ur_cnt - ur0),    32'(vecs[v].exp_ur));
            check("miso_done",  32'(miso),            32'd0);
            cs = 1'b1;
            tick(3);
            check("frame_err_n", 32'(ferr_cnt - fe0), 32'd0);
            check("busy_end",    32'(busy),           32'd0);
        end

        // Abort after 5 sclk cycles.
        rxv0 = rxv_cnt; fe0 = ferr_cnt;
        cs = 1'b0;
        tick(4);
        shift_bits(12'hABC, 5, got);
        cs = 1'b1;
        tick(3);
        check("abort_ferr",    32'(ferr_cnt - fe0), 32'd1);
        check("abort_rxv",     32'(rxv_cnt - rxv0), 32'd0);
        check("abort_rx_data", 32'(rx_data),        32'h800);
        check("abort_busy",    32'(busy),           32'd0);
        check("abort_miso",    32'(miso),           32'd0);

        // Back-to-back frames, reload during the first, cs high for 2 clk.
        load_tx(12'h123);
        rxv0 = rxv_cnt;
        cs = 1'b0;
        tick(4);
        check("b2b_ready1", 32'(tx_ready), 32'd1);
        load_tx(12'h456);
        check("b2b_full", 32'(tx_ready), 32'd0);
        shift_bits(12'hFFF, N, got);
        tick(2);
        check("b2b_miso1", 32'(got),     32'h123);
        check("b2b_rx1",   32'(rx_data), 32'hFFF);
        cs = 1'b1;
        tick(2);
        cs = 1'b0;
        tick(4);
        check("b2b_ready2", 32'(tx_ready), 32'd1);
        check("b2b_busy2",  32'(busy),     32'd1);
        shift_bits(12'h000, N, got);
        tick(2);
        check("b2b_miso2", 32'(got),            32'h456);
        check("b2b_rx2",   32'(rx_data),        32'h000);
        check("b2b_rxv",   32'(rxv_cnt - rxv0), 32'd2);
        cs = 1'b1;
        tick(3);

        // Reset mid-frame with cs held low.
        load_tx(12'h777);
        rxv0 = rxv_cnt; fe0 = ferr_cnt; ur0 = ur_cnt;
        cs = 1'b0;
        tick(4);
        shift_bits(12'h5A5, 6, got);
        rst = 1'b1;
        tick(2);
        check("mrst_miso",     32'(miso),     32'd0);
        check("mrst_tx_ready", 32'(tx_ready), 32'd1);
        check("mrst_rx_data",  32'(rx_data),  32'd0);
        check("mrst_busy",     32'(busy),     32'd0);
        rst = 1'b0;
        tick(6);
        check("mrst_no_start", 32'(busy), 32'd0);
        shift_bits(12'h5A5, 3, got);
        check("mrst_pulses", 32'((rxv_cnt - rxv0) + (ferr_cnt - fe0) + (ur_cnt - ur0)), 32'd0);
        check("mrst_idle",   32'(busy), 32'd0);
        cs = 1'b1;
        tick(3);
        load_tx(12'h9C3);
        cs = 1'b0;
        tick(4);
        shift_bits(12'h2B4, N, got);
        tick(2);
        check("mrst_miso_word", 32'(got),            32'h9C3);
        check("mrst_rx",        32'(rx_data),        32'h2B4);
        check("mrst_rxv",       32'(rxv_cnt - rxv0), 32'd1);

        // Trailing 13th sclk edge while in DONE.
        mosi = 1'b1;
        sclk = 1'b1;
        tick(4);
        check("extra_miso", 32'(miso), 32'd0);
        sclk = 1'b0;
        tick(4);
        check("extra_rxv",  32'(rxv_cnt - rxv0), 32'd1);
        check("extra_rx",   32'(rx_data),        32'h2B4);
        check("extra_busy", 32'(busy),           32'd1);
        cs = 1'b1;
        tick(3);
        check("extra_ferr", 32'(ferr_cnt - fe0), 32'd0);
        check("extra_idle", 32'(busy),           32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI slave endpoint that pairs with the team's `spi_master` on the same board-level link. It oversamples `sclk`, `cs` and `mosi` with the system clock `clk`. It shifts in one `SPI_TRF_BIT`-wide word MSB-first on `sclk` falling edges and shifts out a buffered response word on `miso`, one bit per `sclk` rising edge. Completed words go to local logic through a valid pulse; outgoing words come in through a valid/ready handshake.

## Interface
- `SPI_TRF_BIT`, 12, word length in bits (2..15).
- `clk` input 1: system clock; must run at least 4× `sclk`.
- `rst` input 1: reset, asynchronous, active-high.
- `sclk` input 1: SPI clock from the master; idles low.
- `cs` input 1: chip select, active-low.
- `mosi` input 1: serial data from the master.
- `miso` output 1: serial data to the master.
- `tx_data` input `SPI_TRF_BIT`: response word to load.
- `tx_valid` input 1: `tx_data` is valid.
- `tx_ready` output 1: TX buffer empty; a load is accepted when `tx_valid && tx_ready`.
- `rx_data` output `SPI_TRF_BIT`: last complete received word; held until the next completion.
- `rx_valid` output 1: one-`clk` pulse when a complete word is received.
- `frame_err` output 1: one-`clk` pulse when a frame aborts before `SPI_TRF_BIT` bits.
- `tx_underrun` output 1: one-`clk` pulse when a frame starts with the TX buffer empty.
- `busy` output 1: high while in `SHIFT` or `DONE`.

## Operation
- Edge detection:
  - Registered previous values `sclk_q` and `cs_q`.
  - `sclk_rise = ~sclk_q & sclk_s`; `sclk_fall = sclk_q & ~sclk_s`; `cs_fall = cs_q & ~cs_s`.
  - `_s` denotes the (optionally synchronised) inputs.
- TX buffer:
  - One word `tx_buf` plus flag `tx_full`. `tx_ready = ~tx_full`.
  - Load on handshake. At frame start, copy to shift register `tx_sr` and clear `tx_full`.
  - If empty at frame start: `tx_sr = 0` and pulse `tx_underrun`.
- FSM:
  - `IDLE`: `bit_cnt=0`, `miso=0`. On `cs_fall`: load `tx_sr`, go to `SHIFT`.
  - `SHIFT`:
    - On `sclk_rise` with `tx_cnt < SPI_TRF_BIT`: `miso <= tx_sr[SPI_TRF_BIT-1]`, shift `tx_sr` left, `tx_cnt++`.
    - On `sclk_fall` with `bit_cnt < SPI_TRF_BIT`: `rx_sr <= {rx_sr, mosi_s}`, `bit_cnt++`.
    - When `bit_cnt` reaches `SPI_TRF_BIT`: go to `DONE`.
  - `DONE`: `rx_data <= rx_sr`, pulse `rx_valid`, `miso <= 0`. Then wait for `cs_s` high and go to `IDLE`.
- Abort: `cs_s` rising while in `SHIFT` → pulse `frame_err`, discard `rx_sr`, no `rx_valid`, `miso=0`, go to `IDLE`. `tx_buf` is not restored.
- Extra edges:
  - Further `sclk` edges while in `DONE` with `cs` low (the master's trailing edge) are ignored.
  - `rx_valid` fires exactly once per frame.
- Same-cycle events:
  - `sclk_rise` and `sclk_fall` cannot coincide.
  - `cs_fall` and a TX handshake in the same cycle: the new word goes to `tx_buf` for the next frame. The current frame takes the prior buffer contents, or underruns.
- Counters: `bit_cnt` and `tx_cnt` are 4 bits wide and saturate at `SPI_TRF_BIT`.

## Timing
- Reset values: `miso=0`, `tx_ready=1`, `rx_data=0`, `rx_valid=0`, `frame_err=0`, `tx_underrun=0`, `busy=0`, FSM in `IDLE`, all shift registers 0.
- Reset mid-frame: the frame is dropped with no pulses. After release, the slave waits for the next `cs_fall`; the current low `cs` does not start a frame.
- Input-to-edge latency: 1 `clk` without synchroniser, 3 `clk` with it.
- `miso` changes 1 `clk` after the detected rising edge. It is stable long before the master's falling-edge sample, given the 4× ratio.
- `rx_valid` is asserted 1 `clk` after the detected falling edge that carries bit `SPI_TRF_BIT`.
- Back-to-back frames are supported provided `cs` stays high for ≥2 `clk`.

## Configuration
- `SPI_SLAVE_SYNC_EN` defined: `sclk`, `cs` and `mosi` each pass through a 2-flop synchroniser (reset 0, 1, 0) before edge detection. Use this for asynchronous masters.
- Not defined: the inputs feed edge detection directly, which is valid only when the master shares `clk`. Latency drops by 2 `clk`.

## Structure
- Shared package `spi_pkg`:
  - `SPI_TRF_BIT` default.
  - FSM state encodings `IDLE=2'b00`, `SHIFT=2'b01`, `DONE=2'b10`.
- Sub-module `spi_edge_detect`: optional synchroniser plus rise/fall detector, instantiated once each for `sclk` and `cs`.

## Test plan
- Load `tx_data=12'hA5C`, master full-duplex sends `12'h3F1` → `rx_data=12'h3F1` with one `rx_valid` pulse, and the master receives `12'hA5C`.
- No TX load before `cs` falls, master sends `12'h001` → `tx_underrun` pulse, `miso` all 0, `rx_data=12'h001`.
- `cs` raised after 5 `sclk` cycles → `frame_err` pulse, no `rx_valid`, `rx_data` unchanged, back to `IDLE`.
- Two back-to-back frames `12'hFFF` then `12'h000`, with TX reloaded between them → two `rx_valid` pulses with the correct words, and `tx_ready` rises after each frame start.
- `rst` asserted mid-frame while `cs` stays low → all outputs at reset values, no pulses, and the next full frame is received correctly.
- Master's 13th `sclk` edge while in `DONE` → no extra shift and no second `rx_valid`.
